// File: rtl/cdm16_seq_ctrl_if.sv
// rtl/cdm16_seq_ctrl_if.sv - operand/result handshake bundle for the sequenced carry-disregard multiplier
interface cdm16_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R;
    logic        busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, R, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, R, busy
    );
endinterface

// File: rtl/cdm16_seq_ctrl.sv
// rtl/cdm16_seq_ctrl.sv - 16x16 multiplier sharing one 8x8 unit over four steps, byte lanes without inter-lane carry
// CDM_SEQ_EXACT_CARRY_EN selects full carry propagation between lanes (exact product).
module cdm16_seq_ctrl (
    input  logic              clk,
    input  logic              rst,
    cdm16_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [15:0]      a_q, b_q;
    logic [3:0][7:0]  lane_q, lane_d;

    logic             accept;
    logic [7:0]       mul_x, mul_y;
    logic [15:0]      pp;
    logic [1:0]       base_lane;

    assign accept = bus.in_valid && (state_q == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_MUL;
                    step_d  = 2'd0;
                end
            end
            S_MUL: begin
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 2'd0;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q == S_MUL) || (state_q == S_DONE);
        bus.R         = lane_q;
    end

    // step[0] picks the A byte, step[1] the B byte: LL, HL, LH, HH
    always_comb begin
        mul_x = step_q[0] ? a_q[15:8] : a_q[7:0];
        mul_y = step_q[1] ? b_q[15:8] : b_q[7:0];
        pp    = {8'd0, mul_x} * {8'd0, mul_y};
    end

    always_comb begin
        case (step_q)
            2'd0:    base_lane = 2'd0;
            2'd1:    base_lane = 2'd1;
            2'd2:    base_lane = 2'd1;
            default: base_lane = 2'd2;
        endcase
    end

`ifdef CDM_SEQ_EXACT_CARRY_EN
    logic [31:0] acc_sum;

    always_comb begin
        acc_sum = lane_q + ({16'd0, pp} << {base_lane, 3'b000});
        lane_d  = acc_sum;
    end
`else
    // Each lane wraps mod 256; carries out of a lane are dropped.
    always_comb begin
        lane_d                    = lane_q;
        lane_d[base_lane]         = lane_q[base_lane] + pp[7:0];
        lane_d[base_lane + 2'd1]  = lane_q[base_lane + 2'd1] + pp[15:8];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 2'd0;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            lane_q <= '0;
        end else begin
            step_q <= step_d;
            if (accept) begin
                a_q    <= bus.A;
                b_q    <= bus.B;
                lane_q <= '0;
            end else if (state_q == S_MUL) begin
                lane_q <= lane_d;
            end
        end
    end

endmodule

// File: tb/tb_cdm16_seq_ctrl.sv
// tb/tb_cdm16_seq_ctrl.sv - scoreboard bench for cdm16_seq_ctrl (honours CDM_SEQ_EXACT_CARRY_EN)
module tb_cdm16_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   results;
    int   requests;
    logic [31:0] exp_q[$];
    logic [31:0] r;

    cdm16_seq_ctrl_if bus ();

    cdm16_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef CDM_SEQ_EXACT_CARRY_EN
        return {16'd0, a} * {16'd0, b};
`else
        logic [15:0] ll, hl, lh, hh;
        logic [7:0]  l0, l1, l2, l3;
        ll = a[7:0]  * b[7:0];
        hl = a[15:8] * b[7:0];
        lh = a[7:0]  * b[15:8];
        hh = a[15:8] * b[15:8];
        l0 = ll[7:0];
        l1 = ll[15:8] + hl[7:0] + lh[7:0];
        l2 = hl[15:8] + lh[15:8] + hh[7:0];
        l3 = hh[15:8];
        return {l3, l2, l1, l0};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_send", bus.in_ready, 1);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(a, b));
        requests++;
        check("in_ready_after_accept", bus.in_ready, 0);
        check("busy_after_accept", bus.busy, 1);
        check("R_cleared_at_accept", bus.R, 0);
    endtask

    task automatic recv(input int stall_pct, input int hold, output logic [31:0] res);
        int n;
        logic [31:0] exp;
        logic ready;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            check("in_ready_low_mul", bus.in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 4);
        check("out_valid_rise", bus.out_valid, 1);
        check("sb_size", 32'(exp_q.size()), 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        res = bus.R;
        check("R", res, exp);
        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_R", bus.R, res);
            check("hold_busy", bus.busy, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        for (int k = 0; k < 40; k++) begin
            ready = (k >= 20) || ($urandom_range(0, 99) >= stall_pct);
            bus.out_ready = ready;
            @(posedge clk); #1;
            if (ready) break;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_R", bus.R, res);
        end
        bus.out_ready = 1'b0;
        check("out_valid_consumed", bus.out_valid, 0);
        check("in_ready_after_consume", bus.in_ready, 1);
        check("R_kept_idle", bus.R, res);
        results++;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        results       = 0;
        requests      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = 16'd0;
        bus.B         = 16'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_R", bus.R, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(16'h0102, 16'h0304);
        recv(0, 0, r);
        check("R_0102x0304", r, 32'h0003_0A08);

        send(16'hFFFF, 16'hFFFF);
        recv(0, 0, r);
`ifdef CDM_SEQ_EXACT_CARRY_EN
        check("R_FFFFxFFFF", r, 32'hFFFE_0001);
`else
        check("R_FFFFxFFFF", r, 32'hFEFD_0001);
`endif

        send(16'h1234, 16'h0000);
        recv(0, 10, r);
        check("R_1234x0000", r, 32'h0000_0000);

        // A second request held on in_valid through MUL and DONE must wait for consume
        send(16'h00FF, 16'h0101);
        bus.A        = 16'hAAAA;
        bus.B        = 16'h5555;
        bus.in_valid = 1'b1;
        recv(0, 3, r);
        check("R_first_unaffected", r, model(16'h00FF, 16'h0101));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(16'hAAAA, 16'h5555));
        requests++;
        check("late_accept_busy", bus.busy, 1);
        check("late_accept_R_clear", bus.R, 0);
        recv(0, 0, r);

        // Reset during step 2 drops the in-flight request
        send(16'hFFFF, 16'hFFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_R", bus.R, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", bus.busy, 0);
        void'(exp_q.pop_back());
        requests--;
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(16'h0002, 16'h0003);
        recv(0, 0, r);
        check("R_after_rst", r, 32'h0000_0006);

        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 16'($urandom));
            recv(30, 0, r);
        end

        check("results_vs_requests", 32'(results), 32'(requests));
        check("sb_empty_end", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
